// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_scheduler
// Purpose  : Round-robin sharing of one N-bit add/sub/and/xor ALU between
//            NREQ valid/ready requesters, with a tagged, registered response.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler #(
    parameter  int N    = 8,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_result,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    localparam logic [IDW-1:0] c_ptr_last = IDW'(NREQ - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [2:0]     r_op;
    logic [IDW-1:0] r_id;

    logic [N-1:0]   r_rsp_result;
    logic [IDW-1:0] r_rsp_id;
    logic           r_rsp_carry;
    logic           r_rsp_zero;
    logic           r_rsp_err;

    logic           w_gnt_found;
    logic [IDW-1:0] w_gnt_idx;
    logic           w_grant_ok;
    int             w_cand;
    logic [N:0]     w_wide;
    logic           w_alu_err;

    // First valid requester at or after the pointer, searching with wrap.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = (int'(r_ptr) + k) % NREQ;
            if (!w_gnt_found && req_valid[IDW'(w_cand)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IDW'(w_cand);
            end
        end
    end

    // Reset wins: no transfer may complete in a reset cycle.
    assign w_grant_ok = (r_state == S_IDLE) && w_gnt_found && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_found) begin
                    w_state_nxt = S_EXEC;
                end
                if (w_grant_ok) begin
                    req_ready = NREQ'(1) << w_gnt_idx;
                end
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Zero-extended N+1-bit arithmetic: bit N is carry for add, borrow for sub.
    always_comb begin
        w_wide    = '0;
        w_alu_err = 1'b0;
        case (r_op)
            3'b000:  w_wide = {1'b0, r_a} + {1'b0, r_b};
            3'b001:  w_wide = {1'b0, r_a} - {1'b0, r_b};
            3'b010:  w_wide = {1'b0, r_a & r_b};
            3'b011:  w_wide = {1'b0, r_a ^ r_b};
            default: begin
                w_wide    = {1'b0, {N{1'b1}}};
                w_alu_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_id         <= '0;
            r_rsp_result <= '0;
            r_rsp_id     <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_grant_ok) begin
                r_a   <= req_a[w_gnt_idx*N +: N];
                r_b   <= req_b[w_gnt_idx*N +: N];
                r_op  <= req_op[w_gnt_idx*3 +: 3];
                r_id  <= w_gnt_idx;
                r_ptr <= (w_gnt_idx == c_ptr_last) ? '0 : w_gnt_idx + IDW'(1);
            end
            if (r_state == S_EXEC) begin
                r_rsp_result <= w_wide[N-1:0];
                r_rsp_id     <= r_id;
                r_rsp_carry  <= w_wide[N];
                r_rsp_zero   <= (w_wide[N-1:0] == '0);
                r_rsp_err    <= w_alu_err;
            end
        end
    end

    assign rsp_valid  = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign rsp_result = r_rsp_result;
    assign rsp_id     = r_rsp_id;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_scheduler
// Purpose  : Self-checking bench for alu_rr_scheduler (vectors + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_scheduler;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic         err;
        logic         carry;
        logic         zero;
        logic [N-1:0] res;
    } rsp_t;

    typedef struct {
        int           req;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
        rsp_t         exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_result;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_carry;
    logic              rsp_zero;
    logic              rsp_err;
    logic              busy;

    logic [N-1:0] v_a  [NREQ];
    logic [N-1:0] v_b  [NREQ];
    logic [2:0]   v_op [NREQ];

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = v_a[i];
            req_b[i*N +: N] = v_b[i];
            req_op[i*3 +: 3] = v_op[i];
        end
    end

    alu_rr_scheduler #(.N(N), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: first valid index scanning upward from p with wrap.
    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference ALU in plain integer arithmetic.
    function automatic rsp_t alu_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                     input logic [2:0] op);
        int   lim = 1 << N;
        int   ia  = int'(a);
        int   ib  = int'(b);
        int   r   = 0;
        rsp_t o;
        o.carry = 1'b0;
        o.err   = 1'b0;
        case (op)
            3'd0: begin r = ia + ib; o.carry = (r >= lim); r = r % lim; end
            3'd1: begin o.carry = (ia < ib); r = (ia - ib + lim) % lim; end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a ^ b);
            default: begin r = lim - 1; o.err = 1'b1; end
        endcase
        o.res  = N'(r);
        o.zero = (r == 0);
        return o;
    endfunction

    function automatic vec_t mk(input int r, input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] op, input logic [7:0] res,
                                input logic c, input logic z, input logic e);
        vec_t v;
        v.req = r; v.a = a; v.b = b; v.op = op;
        v.exp.res = res; v.exp.carry = c; v.exp.zero = z; v.exp.err = e;
        return v;
    endfunction

    task automatic rerand(input int i);
        req_valid[i] = 1'($urandom);
        v_a[i]  = N'($urandom);
        v_b[i]  = N'($urandom);
        v_op[i] = 3'($urandom_range(0, 7));
    endtask

    // One full transaction from an IDLE cycle (entered just after a posedge).
    // mode: 0 drop the winner's valid after handshake, 1 keep it, 2 re-randomize it.
    task automatic run_txn(input int delay, input int mode, output rsp_t got, output int gid);
        int   w;
        int   n;
        rsp_t e;
        got = '0;
        gid = -1;
        w = pick(req_valid, m_ptr);
        @(negedge clk);
        n = 0;
        while (req_ready == '0 && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("grant_wait", 32'(n), 32'd0);
        chk("grant_onehot", 32'(req_ready), (w < 0) ? 32'd0 : 32'(1 << w));
        if (w < 0 || n >= 20) return;
        e = alu_ref(v_a[w], v_b[w], v_op[w]);
        m_ptr = (w + 1) % NREQ;
        rsp_ready = (delay == 0);
        @(posedge clk); #1;
        if (mode == 0) req_valid[w] = 1'b0;
        else if (mode == 2) rerand(w);
        @(negedge clk);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_req_ready", 32'(req_ready), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        got = {rsp_err, rsp_carry, rsp_zero, rsp_result};
        gid = int'(rsp_id);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_fields", 32'(got), 32'(e));
        chk("rsp_id", 32'(rsp_id), 32'(w));
        for (int d = 1; d <= delay; d++) begin
            @(posedge clk); #1;
            if (d == delay) rsp_ready = 1'b1;
            @(negedge clk);
            chk("hold_rsp", 32'({rsp_valid, rsp_err, rsp_carry, rsp_zero, rsp_result, rsp_id}),
                32'({1'b1, e, IDW'(w)}));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [9];
        int   rr_exp [8];
        rsp_t got;
        int   gid;

        tbl[0] = mk(0, 8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(1, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0);
        tbl[2] = mk(2, 8'h03, 8'h05, 3'b001, 8'hFE, 1'b1, 1'b0, 1'b0);
        tbl[3] = mk(3, 8'h5A, 8'h5A, 3'b011, 8'h00, 1'b0, 1'b1, 1'b0);
        tbl[4] = mk(0, 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, 1'b0, 1'b0);
        tbl[5] = mk(1, 8'h12, 8'h34, 3'b101, 8'hFF, 1'b0, 1'b0, 1'b1);
        tbl[6] = mk(2, 8'h05, 8'h03, 3'b001, 8'h02, 1'b0, 1'b0, 1'b0);
        tbl[7] = mk(3, 8'h00, 8'h00, 3'b111, 8'hFF, 1'b0, 1'b0, 1'b1);
        tbl[8] = mk(0, 8'h00, 8'h00, 3'b001, 8'h00, 1'b0, 1'b1, 1'b0);
        rr_exp = '{0, 1, 2, 3, 0, 1, 3, 1};

        rst = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        for (int i = 0; i < NREQ; i++) begin
            v_a[i] = N'(8'h10 * (i + 1)); v_b[i] = N'(i); v_op[i] = 3'b000;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_outputs", 32'({req_ready, rsp_valid, rsp_result, rsp_id, rsp_carry, rsp_zero, rsp_err, busy}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0;

        // Round robin with all requesters valid, then only 1 and 3.
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) req_valid = 4'b1010;
            run_txn(0, 1, got, gid);
            chk("rr_order", 32'(gid), 32'(rr_exp[i]));
        end

        for (int i = 0; i < 9; i++) begin
            req_valid = '0;
            req_valid[tbl[i].req] = 1'b1;
            v_a[tbl[i].req] = tbl[i].a;
            v_b[tbl[i].req] = tbl[i].b;
            v_op[tbl[i].req] = tbl[i].op;
            run_txn(0, 0, got, gid);
            chk("tbl_result", 32'(got), 32'(tbl[i].exp));
            chk("tbl_id", 32'(gid), 32'(tbl[i].req));
        end

        // Backpressure: five stalled response cycles, then immediate regrant.
        req_valid = 4'b1111;
        run_txn(5, 1, got, gid);
        run_txn(0, 1, got, gid);

        // Reset during RESP with req2/req3 pending; pointer restarts at 0.
        req_valid = 4'b0100;
        v_a[2] = 8'h10; v_b[2] = 8'h20; v_op[2] = 3'b000;
        @(negedge clk);
        chk("rst_pre_grant", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = 4'b1100;
        v_a[2] = 8'h01; v_b[2] = 8'h02;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_rsp", 32'({rsp_valid, rsp_id}), 32'({1'b1, 2'd2}));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0;
        chk("rst_abort_outputs", 32'({rsp_valid, rsp_result, rsp_id, rsp_carry, rsp_zero, rsp_err, busy}), 32'd0);
        run_txn(0, 0, got, gid);
        chk("rst_regrant_id", 32'(gid), 32'd2);
        chk("rst_regrant_res", 32'(got.res), 32'h03);

        // Randomized traffic against the reference model.
        for (int i = 0; i < NREQ; i++) rerand(i);
        for (int t = 0; t < 60; t++) begin
            if (req_valid == '0) req_valid[$urandom_range(0, NREQ - 1)] = 1'b1;
            run_txn(int'($urandom_range(0, 3)), 2, got, gid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
